// File: rtl/imem_arbiter.sv
// imem_arbiter
// Single-port instruction-memory arbiter between the fetch stage (f_*), the
// watermark extraction reader (w_*) and a synchronous-read instruction memory.
// Each cycle at most one requester is granted. The grant drives mem_addr, and
// the one-cycle-latency read data returns to the owner with a valid strobe.
// Fetch has priority.
//
// Optional feature: define IMEM_ARB_AGING_EN to build the aging counter. While
// the watermark is refused, the counter counts up to MAX_WAIT. When it reaches
// MAX_WAIT, the watermark wins one grant even under fetch contention.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   f_req/f_addr      fetch request and word address (held until f_gnt)
//   f_gnt             fetch granted this cycle (combinational)
//   f_valid/f_data    fetch read data, one cycle after f_gnt
//   w_req/w_addr      watermark request and word address (held until w_gnt)
//   w_gnt             watermark granted this cycle (combinational)
//   w_valid/w_data    watermark read data, one cycle after w_gnt
//   mem_addr          word index to the memory (holds the last issued index)
//   mem_data          registered memory output
module imem_arbiter #(
  parameter int ADDR_W   = 7,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic              f_gnt,
  output logic              f_valid,
  output logic [31:0]       f_data,
  input  logic              w_req,
  input  logic [31:0]       w_addr,
  output logic              w_gnt,
  output logic              w_valid,
  output logic [31:0]       w_data,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_data
);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_WM    = 2'd2
  } owner_e;

  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              age_flag;

`ifdef IMEM_ARB_AGING_EN
  localparam logic [7:0] AGE_MAX = 8'(MAX_WAIT);

  logic [7:0] age_q, age_d;

  assign age_flag = (age_q == AGE_MAX);

  // The counter restarts whenever the watermark is served or withdraws. It
  // saturates so the override flag stays up until a grant actually occurs.
  always_comb begin
    age_d = age_q;
    if (!w_req || w_gnt)
      age_d = 8'd0;
    else if (age_q != AGE_MAX)
      age_d = age_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) age_q <= 8'd0;
    else     age_q <= age_d;
  end

  logic unused_addr_hi;
  assign unused_addr_hi = ^{f_addr[31:ADDR_W], w_addr[31:ADDR_W]};
`else
  // Strict fetch priority. MAX_WAIT has no effect in this build.
  assign age_flag = 1'b0;

  logic unused_addr_hi;
  assign unused_addr_hi = ^{f_addr[31:ADDR_W], w_addr[31:ADDR_W], 8'(MAX_WAIT)};
`endif

  // Grant: fetch wins unless the aged watermark is also asking.
  always_comb begin
    f_gnt = 1'b0;
    w_gnt = 1'b0;
    if (!rst) begin
      if (f_req && !(w_req && age_flag))
        f_gnt = 1'b1;
      else if (w_req)
        w_gnt = 1'b1;
    end
  end

  // With no grant, the address bus parks on the last issued index.
  always_comb begin
    mem_addr_d = mem_addr_q;
    if (f_gnt)
      mem_addr_d = f_addr[ADDR_W-1:0];
    else if (w_gnt)
      mem_addr_d = w_addr[ADDR_W-1:0];
  end

  assign mem_addr = mem_addr_d;

  // The owner records who was granted. The memory answers one cycle later,
  // so the owner qualifies the data in that following cycle.
  always_comb begin
    owner_d = OWN_NONE;
    if (f_gnt)
      owner_d = OWN_FETCH;
    else if (w_gnt)
      owner_d = OWN_WM;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= OWN_NONE;
      mem_addr_q <= '0;
    end else begin
      owner_q    <= owner_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign f_valid = (owner_q == OWN_FETCH);
  assign w_valid = (owner_q == OWN_WM);
  assign f_data  = mem_data;
  assign w_data  = mem_data;

endmodule
